// File: rtl/button_event_pkg.sv
// Shared types, width helpers and 100 MHz default
// thresholds for the button event detector.
package button_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_GAP,
    ST_SECOND,
    ST_HELD
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_LONG_CYC     = 200_000_000;
  localparam int DEF_GAP_CYC      = 30_000_000;

  function automatic int cnt_width(
    input int long_cyc,
    input int gap_cyc
  );
    int m;
    m = (long_cyc > gap_cyc) ? long_cyc : gap_cyc;
    return $clog2(m + 1);
  endfunction

  function automatic int dbc_width(
    input int debounce_cyc
  );
    return $clog2(debounce_cyc + 1);
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: 2-FF synchroniser, stability
// debounce and short/double/long click classifier.
module button_event_channel
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int GAP_CYC      = DEF_GAP_CYC,
  parameter int DOUBLE_EN    = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic pressed_o,
  output logic press_short_o,
  output logic press_double_o,
  output logic press_long_o,
  output logic held_o
);

  localparam int CW = cnt_width(LONG_CYC, GAP_CYC);
  localparam int DW = dbc_width(DEBOUNCE_CYC);

  // The entry cycle is already high, so the long limit
  // sits two below LONG_CYC to land the pulse on time.
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYC - 2);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [DW-1:0] DB_LIM   = DW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          lvl_q;
  logic [DW-1:0] db_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      db_q    <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      if (sync2_q != lvl_q) begin
        if (db_q == DB_LIM) begin
          lvl_q <= sync2_q;
          db_q  <= '0;
        end else begin
          db_q <= db_q + DW'(1);
        end
      end else begin
        db_q <= '0;
      end
    end
  end

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          held_q, held_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q
                 : cnt_q + CW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    held_d   = held_q;
    unique case (state_q)
      ST_IDLE: begin
        held_d = 1'b0;
        if (lvl_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED, ST_SECOND: begin
        if (lvl_q) begin
          if (cnt_q == LONG_LIM) begin
            long_d  = 1'b1;
            held_d  = 1'b1;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (state_q == ST_SECOND) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (DOUBLE_EN != 0) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        // A rise wins over expiry in the same cycle.
        if (lvl_q) begin
          state_d = ST_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LIM) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!lvl_q) begin
          held_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pressed_o      = lvl_q;
  assign press_short_o  = short_q;
  assign press_double_o = double_q;
  assign press_long_o   = long_q;
  assign held_o         = held_q;

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel button front end: N_CH independent
// debounced short/double/long click detectors.
module button_event_detector
  import button_event_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int GAP_CYC      = DEF_GAP_CYC,
  parameter int DOUBLE_EN    = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] pressed_o,
  output logic [N_CH-1:0] press_short_o,
  output logic [N_CH-1:0] press_double_o,
  output logic [N_CH-1:0] press_long_o,
  output logic [N_CH-1:0] held_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_event_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .GAP_CYC      (GAP_CYC),
      .DOUBLE_EN    (DOUBLE_EN)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .button_i       (button_i[i]),
      .pressed_o      (pressed_o[i]),
      .press_short_o  (press_short_o[i]),
      .press_double_o (press_double_o[i]),
      .press_long_o   (press_long_o[i]),
      .held_o         (held_o[i])
    );
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Scoreboard bench: two detectors (DOUBLE_EN 0 and 1)
// share the same buttons; pulses are matched by cycle.
module tb_button_event_detector;

  localparam int D = 4;
  localparam int L = 20;
  localparam int G = 10;

  localparam int K_SHORT  = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;

  typedef struct {
    int cyc;
    int dut;
    int ch;
    int kind;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] button;
  logic [1:0] pr[2];
  logic [1:0] sh[2];
  logic [1:0] db[2];
  logic [1:0] lg[2];
  logic [1:0] hd[2];

  exp_t q[$];
  int   cyc;
  int   tests;
  int   fails;

  button_event_detector #(
    .N_CH(2), .DEBOUNCE_CYC(D), .LONG_CYC(L),
    .GAP_CYC(G), .DOUBLE_EN(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .button_i(button),
    .pressed_o(pr[0]), .press_short_o(sh[0]),
    .press_double_o(db[0]), .press_long_o(lg[0]),
    .held_o(hd[0])
  );

  button_event_detector #(
    .N_CH(2), .DEBOUNCE_CYC(D), .LONG_CYC(L),
    .GAP_CYC(G), .DOUBLE_EN(1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .button_i(button),
    .pressed_o(pr[1]), .press_short_o(sh[1]),
    .press_double_o(db[1]), .press_long_o(lg[1]),
    .held_o(hd[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pulse(int d, int c, int k);
    case (k)
      K_SHORT:  return sh[d][c];
      K_DOUBLE: return db[d][c];
      default:  return lg[d][c];
    endcase
  endfunction

  // Scoreboard: every observed pulse must pop a matching
  // expectation; expectations whose cycle passed are misses.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++)
          for (int k = 0; k < 3; k++)
            if (pulse(d, c, k) === 1'b1) begin
              bit found;
              found = 0;
              for (int i = 0; i < q.size() && !found; i++)
                if (q[i].cyc == cyc && q[i].dut == d &&
                    q[i].ch == c && q[i].kind == k) begin
                  q.delete(i);
                  found = 1;
                end
              tests++;
              if (!found) begin
                fails++;
                $display("FAIL unexpected_pulse dut%0d ch%0d kind%0d cyc %0d got 1 want 0",
                         d, c, k, cyc);
              end
            end
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].cyc <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missed_pulse dut%0d ch%0d kind%0d cyc %0d got 0 want 1",
                   q[i].dut, q[i].ch, q[i].kind, q[i].cyc);
          q.delete(i);
        end
    end
  end

  task automatic push(int d, int c, int k, int at);
    exp_t e;
    e.cyc = at; e.dut = d; e.ch = c; e.kind = k;
    q.push_back(e);
  endtask

  // Drives up to two high intervals per channel (t-relative)
  // and checks pressed_o/held_o against the timing formulas.
  task automatic wave(input int len,
                      input int a0, input int b0,
                      input int c0, input int d0,
                      input int a1, input int b1,
                      input int c1, input int d1);
    int lo[4];
    int hi[4];
    lo = '{a0, c0, a1, c1};
    hi = '{b0, d0, b1, d1};
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        logic ep, eh, bv;
        ep = 0; eh = 0; bv = 0;
        for (int j = 0; j < 2; j++) begin
          int k;
          k = 2 * c + j;
          if (hi[k] > lo[k]) begin
            if (t >= lo[k] && t < hi[k]) bv = 1;
            if (t >= lo[k] + 2 + D && t < hi[k] + 2 + D)
              ep = 1;
            if (hi[k] - lo[k] >= L &&
                t >= lo[k] + 2 + D + L && t < hi[k] + 3 + D)
              eh = 1;
          end
        end
        for (int d = 0; d < 2; d++) begin
          tests++;
          if (pr[d][c] !== ep) begin
            fails++;
            $display("FAIL pressed dut%0d ch%0d t%0d got %b want %b",
                     d, c, t, pr[d][c], ep);
          end
          tests++;
          if (hd[d][c] !== eh) begin
            fails++;
            $display("FAIL held dut%0d ch%0d t%0d got %b want %b",
                     d, c, t, hd[d][c], eh);
          end
        end
        button[c] = bv;
      end
    end
  endtask

  task automatic check_all_zero(string name);
    for (int d = 0; d < 2; d++) begin
      logic [9:0] v;
      v = {pr[d], sh[d], db[d], lg[d], hd[d]};
      tests++;
      if (v !== 10'b0) begin
        fails++;
        $display("FAIL %s dut%0d got %b want 0", name, d, v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button = 2'b00;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_short();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_SHORT, n + 10 + 3 + D);
    push(1, 0, K_SHORT, n + 10 + 3 + D + G);
    wave(40, 0, 10, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_long();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_LONG, n + 2 + D + L);
    push(1, 0, K_LONG, n + 2 + D + L);
    wave(50, 0, 30, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_double();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 1, K_SHORT, n + 6 + 3 + D);
    push(0, 1, K_SHORT, n + 18 + 3 + D);
    push(1, 1, K_DOUBLE, n + 18 + 3 + D);
    wave(45, 0, 0, 0, 0, 0, 6, 12, 18);
  endtask

  task automatic test_wide_gap();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_SHORT, n + 6 + 3 + D);
    push(0, 0, K_SHORT, n + 27 + 3 + D);
    push(1, 0, K_SHORT, n + 6 + 3 + D + G);
    push(1, 0, K_SHORT, n + 27 + 3 + D + G);
    wave(60, 0, 6, 21, 27, 0, 0, 0, 0);
  endtask

  task automatic test_gap_boundary();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_SHORT, n + 6 + 3 + D);
    push(0, 0, K_SHORT, n + 22 + 3 + D);
    push(1, 0, K_DOUBLE, n + 22 + 3 + D);
    wave(45, 0, 6, 6 + G, 12 + G, 0, 0, 0, 0);
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (pr[d] !== 2'b00) begin
          fails++;
          $display("FAIL glitch_pressed dut%0d t%0d got %b want 00",
                   d, t, pr[d]);
        end
      end
      button = (t < 48 && (t % 8) < 3) ? 2'b11 : 2'b00;
    end
  endtask

  task automatic test_independent();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_LONG, n + 2 + D + L);
    push(1, 0, K_LONG, n + 2 + D + L);
    push(0, 1, K_SHORT, n + 7 + 3 + D);
    push(0, 1, K_SHORT, n + 30 + 3 + D);
    push(1, 1, K_SHORT, n + 7 + 3 + D + G);
    push(1, 1, K_SHORT, n + 30 + 3 + D + G);
    wave(60, 0, 30, 0, 0, 2, 7, 25, 30);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    button = 2'b01;
    repeat (14) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (pr[d][0] !== 1'b1) begin
        fails++;
        $display("FAIL mid_press_level dut%0d got %b want 1",
                 d, pr[d][0]);
      end
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_drop");
    q.delete();
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b0;
    n = cyc;
    push(0, 0, K_SHORT, n + 10 + 3 + D);
    push(1, 0, K_SHORT, n + 10 + 3 + D + G);
    wave(40, 0, 10, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_second_long();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_SHORT, n + 6 + 3 + D);
    push(0, 0, K_LONG, n + 12 + 2 + D + L);
    push(1, 0, K_LONG, n + 12 + 2 + D + L);
    wave(55, 0, 6, 12, 12 + L, 0, 0, 0, 0);
  endtask

  task automatic test_second_short();
    int n;
    @(negedge clk);
    n = cyc;
    push(0, 0, K_SHORT, n + 6 + 3 + D);
    push(0, 0, K_SHORT, n + 11 + L + 3 + D);
    push(1, 0, K_DOUBLE, n + 11 + L + 3 + D);
    wave(50, 0, 6, 12, 11 + L, 0, 0, 0, 0);
  endtask

  task automatic test_drain();
    repeat (10) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_queue got %0d want 0", q.size());
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    button = 2'b00;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_wide_gap();
    test_gap_boundary();
    test_glitch();
    test_independent();
    test_second_long();
    test_second_short();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
